// File: rtl/axi_lite_slave_regif.sv
// AXI4-Lite slave front end for the UART register block.
// AW, W and AR are captured into single-entry holding registers; a full
// write (address + data) or a pending read is then turned into a one-cycle
// register strobe. Writes take priority over reads when both are ready.
// One write and one read may be outstanding at a time.

module axi_lite_slave_regif #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,

    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,

    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,

    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic                      arvalid,
    output logic                      arready,

    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,

    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0]     reg_wdata,
    output logic                      reg_wen,
    output logic                      reg_ren,
    input  logic [DATA_WIDTH-1:0]     reg_rdata,
    input  logic                      reg_error
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                      aw_full;
    logic                      w_full;
    logic                      ar_full;
    logic [REG_ADDR_WIDTH-1:0] aw_addr_q;
    logic [REG_ADDR_WIDTH-1:0] ar_addr_q;
    logic [DATA_WIDTH-1:0]     w_data_q;
    logic                      wr_exec;
    logic                      rd_exec;

    // Byte strobes and the ignored address bits are intentionally dropped.
    logic unused_inputs;
    assign unused_inputs = ^{wstrb, awaddr, araddr};

    // Handshake readies and strobe generation; reset gates everything so a
    // transaction in flight when rst rises never produces a strobe.
    always_comb begin
        awready   = !aw_full && !bvalid && !rst;
        wready    = !w_full  && !bvalid && !rst;
        arready   = !ar_full && !rvalid && !rst;
        wr_exec   = aw_full && w_full && !bvalid && !rst;
        rd_exec   = ar_full && !rvalid && !wr_exec && !rst;
        reg_wen   = wr_exec;
        reg_ren   = rd_exec;
        reg_addr  = wr_exec ? aw_addr_q : ar_addr_q;
        reg_wdata = w_data_q;
    end

    // Write path: capture AW and W independently, execute, hold B until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            if (awvalid && awready) begin
                aw_full   <= 1'b1;
                aw_addr_q <= awaddr[REG_ADDR_WIDTH+1:2];
            end
            if (wvalid && wready) begin
                w_full   <= 1'b1;
                w_data_q <= wdata;
            end
            if (wr_exec) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= reg_error ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read path: capture AR, execute when no write claims the strobe, hold R.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_full   <= 1'b0;
            ar_addr_q <= '0;
            rvalid    <= 1'b0;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
        end else begin
            if (arvalid && arready) begin
                ar_full   <= 1'b1;
                ar_addr_q <= araddr[REG_ADDR_WIDTH+1:2];
            end
            if (rd_exec) begin
                ar_full <= 1'b0;
                rvalid  <= 1'b1;
                rdata   <= reg_rdata;
                rresp   <= reg_error ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regif.sv
// Bench for axi_lite_slave_regif: emulates the register block, keeps a
// transaction-level model (expected strobes and responses in arrival order,
// plus a shadow of register contents), and checks every cycle.

module tb_axi_lite_slave_regif;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic        reg_ren;
    logic [31:0] reg_rdata;
    logic        reg_error;

    axi_lite_slave_regif #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
        .reg_ren(reg_ren), .reg_rdata(reg_rdata), .reg_error(reg_error)
    );

    always #5 clk = ~clk;

    // Register block emulation: word 15 reports an access error.
    logic [31:0] regs [16];
    assign reg_rdata = regs[reg_addr];
    assign reg_error = (reg_addr == 4'd15);
    always @(posedge clk) if (reg_wen && !reg_error) regs[reg_addr] <= reg_wdata;

    // Transaction-level model.
    typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;
    wr_t         wq  [$];
    logic [3:0]  rq  [$];
    logic [1:0]  bq  [$];
    logic [33:0] rdq [$];
    logic [31:0] exp_mem [16];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a[5:2];
        e.d = d;
        wq.push_back(e);
        if (a[5:2] == 4'd15) bq.push_back(2'b10);
        else begin
            bq.push_back(2'b00);
            exp_mem[a[5:2]] = d;
        end
    endfunction

    function automatic void expect_rd(input logic [31:0] a);
        rq.push_back(a[5:2]);
        rdq.push_back({exp_mem[a[5:2]], (a[5:2] == 4'd15) ? 2'b10 : 2'b00});
    endfunction

    // Per-cycle compare against the model.
    logic       p_bv, p_br, p_rv, p_rr, p_rst;
    logic [1:0] p_bresp, p_rresp;
    logic [31:0] p_rdata;
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                chk("rst_readys", {awready, wready, arready}, 0);
                chk("rst_strobes", {reg_wen, reg_ren}, 0);
            end else begin
                chk("strobe_overlap", reg_wen & reg_ren, 0);
                if (reg_wen) begin
                    chk("wen_expected", wq.size() > 0, 1);
                    if (wq.size() > 0) begin
                        wr_t e;
                        e = wq.pop_front();
                        chk("wen_addr", reg_addr, e.a);
                        chk("wen_data", reg_wdata, e.d);
                    end
                end
                if (reg_ren) begin
                    chk("ren_expected", rq.size() > 0, 1);
                    if (rq.size() > 0) chk("ren_addr", reg_addr, rq.pop_front());
                end
                if (p_bv && !p_br && !p_rst) chk("b_hold", {bvalid, bresp}, {1'b1, p_bresp});
                if (p_rv && !p_rr && !p_rst)
                    chk("r_hold", {rvalid, rresp, rdata}, {1'b1, p_rresp, p_rdata});
                if (bvalid && bready) begin
                    chk("b_expected", bq.size() > 0, 1);
                    if (bq.size() > 0) chk("bresp", bresp, bq.pop_front());
                end
                if (rvalid && rready) begin
                    chk("r_expected", rdq.size() > 0, 1);
                    if (rdq.size() > 0) chk("rdata_rresp", {rdata, rresp}, rdq.pop_front());
                end
            end
        end
        p_bv = bvalid; p_br = bready; p_bresp = bresp;
        p_rv = rvalid; p_rr = rready; p_rresp = rresp; p_rdata = rdata;
        p_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        tick();
        awvalid = 1; awaddr = a; wvalid = 1; wdata = d; bready = 1;
        expect_wr(a, d);
        n = 0;
        smp();
        while (!(awready && wready) && n < 20) begin tick(); smp(); n++; end
        chk("wr_accept_timeout", n < 20, 1);
        tick();
        awvalid = 0; wvalid = 0;
        n = 0;
        smp();
        while (!bvalid && n < 20) begin tick(); smp(); n++; end
        chk("wr_resp_timeout", n < 20, 1);
        resp = bresp;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        tick();
        arvalid = 1; araddr = a; rready = 1;
        expect_rd(a);
        n = 0;
        smp();
        while (!arready && n < 20) begin tick(); smp(); n++; end
        chk("rd_accept_timeout", n < 20, 1);
        tick();
        arvalid = 0;
        n = 0;
        smp();
        while (!rvalid && n < 20) begin tick(); smp(); n++; end
        chk("rd_resp_timeout", n < 20, 1);
        d = rdata;
        resp = rresp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            regs[i]    = 32'hC0DE_0000 | i;
            exp_mem[i] = 32'hC0DE_0000 | i;
        end
        regs[2] = 32'h1234; exp_mem[2] = 32'h1234;
        rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 4'hF; wvalid = 0;
        bready = 0; araddr = 0; arvalid = 0; rready = 0;
        tick();
        mon_en = 1;
        tick();
        smp();
        chk("reset_readys", {awready, wready, arready}, 0);
        tick();
        rst = 0;
        smp();
        chk("post_rst_readys", {awready, wready, arready}, 3'b111);
        chk("post_rst_state", {bvalid, rvalid, bresp, rresp, rdata}, 0);

        // Write 0xA5 to 0x4, AW and W together.
        tick();
        awvalid = 1; awaddr = 32'h4; wvalid = 1; wdata = 32'hA5; bready = 1;
        expect_wr(32'h4, 32'hA5);
        smp(); chk("t1_accept", {awready, wready}, 2'b11);
        tick(); awvalid = 0; wvalid = 0;
        smp(); chk("t1_wen", {reg_wen, reg_addr, reg_wdata}, {1'b1, 4'd1, 32'hA5});
        tick();
        smp(); chk("t1_b", {bvalid, bresp}, {1'b1, 2'b00});
        tick();
        smp(); chk("t1_after_b", {bvalid, awready, wready}, 3'b011);

        // W three cycles before AW.
        tick();
        wvalid = 1; wdata = 32'h11;
        expect_wr(32'hC, 32'h11);
        smp(); chk("t2_w_accept", wready, 1);
        tick(); wvalid = 0;
        smp(); chk("t2_wready_low", wready, 0);
        tick();
        smp(); chk("t2_no_wen", reg_wen, 0);
        tick(); awvalid = 1; awaddr = 32'hC;
        smp(); chk("t2_aw_accept", {awready, reg_wen}, 2'b10);
        tick(); awvalid = 0;
        smp(); chk("t2_wen", {reg_wen, reg_addr, reg_wdata}, {1'b1, 4'd3, 32'h11});
        tick();
        smp(); chk("t2_b", {bvalid, reg_wen}, 2'b10);
        tick();
        smp(); chk("t2_single_b", bvalid, 0);

        // Read 0x8, hold rready low for 5 cycles.
        tick();
        arvalid = 1; araddr = 32'h8; rready = 0;
        expect_rd(32'h8);
        smp(); chk("t3_ar_accept", arready, 1);
        tick(); arvalid = 0;
        smp(); chk("t3_ren", {reg_ren, reg_addr}, {1'b1, 4'd2});
        tick();
        smp(); chk("t3_r", {rvalid, rdata, rresp}, {1'b1, 32'h1234, 2'b00});
        for (int i = 0; i < 5; i++) begin
            tick();
            smp(); chk("t3_hold", {rvalid, rdata, arready}, {1'b1, 32'h1234, 1'b0});
        end
        tick(); rready = 1;
        smp();
        tick(); rready = 0;
        smp(); chk("t3_after_r", {rvalid, arready, rdata}, {1'b0, 1'b1, 32'h1234});

        // Error responses and ignored address bits.
        wr(32'h3C, 32'hBAD, resp);  chk("t4_bresp_err", resp, 2'b10);
        rd(32'h3C, d, resp);        chk("t4_rresp_err", {d, resp}, {32'hC0DE_000F, 2'b10});
        wr(32'h1000_0044, 32'h77, resp); chk("t4_hi_bits_bresp", resp, 2'b00);
        rd(32'h7, d, resp);         chk("t4_low_bits_rd", {d, resp}, {32'h77, 2'b00});
        rd(32'h8, d, resp);         chk("t4_rd2", d, 32'h1234);

        // Write and read eligible together: write first.
        tick();
        awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'h55AA;
        arvalid = 1; araddr = 32'h18; bready = 1; rready = 1;
        expect_wr(32'h14, 32'h55AA);
        expect_rd(32'h18);
        smp(); chk("t5_accept", {awready, wready, arready}, 3'b111);
        tick(); awvalid = 0; wvalid = 0; arvalid = 0;
        smp(); chk("t5_wen_first", {reg_wen, reg_ren, reg_addr}, {1'b1, 1'b0, 4'd5});
        tick();
        smp(); chk("t5_ren_next", {reg_wen, reg_ren, reg_addr, bvalid}, {1'b0, 1'b1, 4'd6, 1'b1});
        tick();
        smp(); chk("t5_r", {rvalid, rdata}, {1'b1, 32'hC0DE_0006});
        tick(); rready = 0;

        // Reset with AW held and R pending: both dropped.
        tick();
        awvalid = 1; awaddr = 32'h10; arvalid = 1; araddr = 32'h1C;
        expect_rd(32'h1C);
        smp(); chk("t6_accept", {awready, arready}, 2'b11);
        tick(); awvalid = 0; arvalid = 0;
        smp();
        tick();
        smp(); chk("t6_rvalid", rvalid, 1);
        tick(); rst = 1;
        rdq.delete();
        smp();
        tick(); rst = 0;
        smp(); chk("t6_post_rst", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
        tick(); wvalid = 1; wdata = 32'hDEAD;
        smp(); chk("t6_w_accept", wready, 1);
        tick(); wvalid = 0;
        smp(); chk("t6_no_wen", reg_wen, 0);
        tick();
        smp(); chk("t6_no_wen_b", {reg_wen, bvalid}, 0);
        tick(); awvalid = 1; awaddr = 32'h20; bready = 1;
        expect_wr(32'h20, 32'hDEAD);
        smp();
        tick(); awvalid = 0;
        smp(); chk("t6_wen_new", {reg_wen, reg_addr, reg_wdata}, {1'b1, 4'd8, 32'hDEAD});
        tick();
        smp(); chk("t6_b", {bvalid, bresp}, {1'b1, 2'b00});
        rd(32'h10, d, resp); chk("t6_dropped_not_written", d, 32'hC0DE_0004);
        rd(32'h20, d, resp); chk("t6_rd_new", d, 32'hDEAD);
        tick(); tick();

        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        chk("bq_drained", bq.size(), 0);
        chk("rdq_drained", rdq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
